// File: rtl/vga_pkg.sv
// Shared constants and encodings for the VGA screen-buffer write path.
package vga_pkg;

    localparam int unsigned NUM_ADDRS   = 600;
    localparam int unsigned ADDR_WIDTH  = 10;
    localparam int unsigned SINGLE_DATA = 7;
    localparam int unsigned STRB_WIDTH  = 4;
    localparam int unsigned DATA_WIDTH  = 28;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDone = 2'd2
    } fill_state_e;

    // Requester indices into the arbiter request/grant vectors.
    localparam int unsigned GNT_AXI  = 0;
    localparam int unsigned GNT_FILL = 1;

endpackage

// File: rtl/vga_rr_arb2.sv
// Two-requester round-robin arbiter; on contention the requester not granted last wins.
module vga_rr_arb2 #(
    parameter logic RESET_LAST = 1'b1
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (gnt_o[1]) begin
            last_d = 1'b1;
        end else if (gnt_o[0]) begin
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_q <= RESET_LAST;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/vga_buffer_wr_arb.sv
// Screen-buffer write-port controller: shares the single write port between AXI
// character writes and a whole-screen fill engine.
module vga_buffer_wr_arb #(
    parameter int unsigned NUM_ADDRS      = vga_pkg::NUM_ADDRS,
    parameter int unsigned ADDR_WIDTH     = vga_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = vga_pkg::DATA_WIDTH,
    parameter int unsigned SINGLE_DATA    = vga_pkg::SINGLE_DATA,
    parameter int unsigned STRB_WIDTH     = vga_pkg::STRB_WIDTH,
    parameter bit          FILL_IN_VBLANK = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   axi_wr_valid_i,
    output logic                   axi_wr_ready_o,
    input  logic [ADDR_WIDTH-1:0]  axi_w_addr_i,
    input  logic [STRB_WIDTH-1:0]  axi_w_strb_i,
    input  logic [DATA_WIDTH-1:0]  axi_din_i,
    input  logic                   fill_start_i,
    input  logic                   fill_abort_i,
    input  logic [SINGLE_DATA-1:0] fill_char_i,
    input  logic                   vblank_i,
    output logic                   fill_busy_o,
    output logic                   fill_done_o,
    output logic                   buf_wr_en_o,
    output logic [ADDR_WIDTH-1:0]  buf_w_addr_o,
    output logic [STRB_WIDTH-1:0]  buf_w_strb_o,
    output logic [DATA_WIDTH-1:0]  buf_din_o
);

    import vga_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_ADDRS - 1);
    localparam logic [ADDR_WIDTH-1:0] AddrLimit = ADDR_WIDTH'(NUM_ADDRS);

    fill_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [SINGLE_DATA-1:0] char_q, char_d;

    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [STRB_WIDTH-1:0]  strb_q, strb_d;
    logic [DATA_WIDTH-1:0]  din_q, din_d;

    logic [1:0] req, gnt;
    logic       fill_req;

    // Abort suppresses the fill request so it can never win the cycle it lands in.
    assign fill_req = (state_q == StFill) && (!FILL_IN_VBLANK || vblank_i) && !fill_abort_i;

    always_comb begin
        req           = 2'b00;
        req[GNT_AXI]  = axi_wr_valid_i;
        req[GNT_FILL] = fill_req;
    end

    vga_rr_arb2 #(
        .RESET_LAST (1'b1)
    ) u_arb (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .req_i  (req),
        .gnt_o  (gnt)
    );

    assign axi_wr_ready_o = gnt[GNT_AXI];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            char_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            char_q  <= char_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        char_d  = char_q;
        unique case (state_q)
            StIdle: begin
                if (fill_start_i) begin
                    state_d = StFill;
                    cnt_d   = '0;
                    char_d  = fill_char_i;
                end
            end
            StFill: begin
                if (fill_abort_i) begin
                    state_d = StDone;
                end else if (gnt[GNT_FILL]) begin
                    if (cnt_q == LastAddr) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fill_busy_o = (state_q == StFill);
        fill_done_o = (state_q == StDone);
    end

    always_comb begin
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        strb_d  = strb_q;
        din_d   = din_q;
        if (gnt[GNT_AXI]) begin
            // Out-of-range writes are acknowledged but leave the port untouched.
            if (axi_w_addr_i < AddrLimit) begin
                wr_en_d = 1'b1;
                addr_d  = axi_w_addr_i;
                strb_d  = axi_w_strb_i;
                din_d   = axi_din_i;
            end
        end else if (gnt[GNT_FILL]) begin
            wr_en_d = 1'b1;
            addr_d  = cnt_q;
            strb_d  = '1;
            din_d   = {STRB_WIDTH{char_q}};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            strb_q  <= '0;
            din_q   <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            din_q   <= din_d;
        end
    end

    assign buf_wr_en_o  = wr_en_q;
    assign buf_w_addr_o = addr_q;
    assign buf_w_strb_o = strb_q;
    assign buf_din_o    = din_q;

endmodule

// File: tb/tb_vga_buffer_wr_arb.sv
// Directed bench for vga_buffer_wr_arb; a second instance covers fill-in-vblank gating.
module tb_vga_buffer_wr_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic        axi_valid;
    logic [9:0]  axi_addr;
    logic [3:0]  axi_strb;
    logic [27:0] axi_din;
    logic        fill_start, fill_abort, vblank;
    logic [6:0]  fill_char;

    logic        axi_ready, fill_busy, fill_done, wr_en;
    logic [9:0]  w_addr;
    logic [3:0]  w_strb;
    logic [27:0] din;

    logic        vb_ready, vb_busy, vb_done, vb_wr_en;
    logic [9:0]  vb_addr;
    logic [3:0]  vb_strb;
    logic [27:0] vb_din;

    int n_checks = 0;
    int n_errors = 0;
    int bad, fidx, busy_cnt;
    logic prev_axi, exp_rdy;
    logic [27:0] exp_fill;

    always #20 clk = ~clk;

    vga_buffer_wr_arb dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .axi_wr_valid_i (axi_valid),
        .axi_wr_ready_o (axi_ready),
        .axi_w_addr_i   (axi_addr),
        .axi_w_strb_i   (axi_strb),
        .axi_din_i      (axi_din),
        .fill_start_i   (fill_start),
        .fill_abort_i   (fill_abort),
        .fill_char_i    (fill_char),
        .vblank_i       (vblank),
        .fill_busy_o    (fill_busy),
        .fill_done_o    (fill_done),
        .buf_wr_en_o    (wr_en),
        .buf_w_addr_o   (w_addr),
        .buf_w_strb_o   (w_strb),
        .buf_din_o      (din)
    );

    vga_buffer_wr_arb #(
        .FILL_IN_VBLANK (1'b1)
    ) dut_vb (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .axi_wr_valid_i (axi_valid),
        .axi_wr_ready_o (vb_ready),
        .axi_w_addr_i   (axi_addr),
        .axi_w_strb_i   (axi_strb),
        .axi_din_i      (axi_din),
        .fill_start_i   (fill_start),
        .fill_abort_i   (fill_abort),
        .fill_char_i    (fill_char),
        .vblank_i       (vblank),
        .fill_busy_o    (vb_busy),
        .fill_done_o    (vb_done),
        .buf_wr_en_o    (vb_wr_en),
        .buf_w_addr_o   (vb_addr),
        .buf_w_strb_o   (vb_strb),
        .buf_din_o      (vb_din)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compares the registered port against the grant predicted for the previous cycle.
    task verify_prev(input logic was_axi);
        if (was_axi) begin
            if (wr_en !== 1'b1 || w_addr !== 10'd10 || din !== 28'h0AAAAAA || w_strb !== 4'hF)
                bad++;
        end else begin
            if (wr_en !== 1'b1 || w_addr !== fidx[9:0] || din !== exp_fill || w_strb !== 4'hF)
                bad++;
            fidx++;
        end
    endtask

    initial begin
        rstn = 1'b0; axi_valid = 1'b0; axi_addr = '0; axi_strb = '0; axi_din = '0;
        fill_start = 1'b0; fill_abort = 1'b0; fill_char = '0; vblank = 1'b1;

        // Reset state
        #1;
        check("rst_wr_en", {31'd0, wr_en}, 0);
        check("rst_addr", {22'd0, w_addr}, 0);
        check("rst_din", {4'd0, din}, 0);
        check("rst_busy_done", {30'd0, fill_busy, fill_done}, 0);
        check("rst_ready", {31'd0, axi_ready}, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Single AXI write
        @(negedge clk);
        axi_valid = 1'b1; axi_addr = 10'd5; axi_strb = 4'b0101; axi_din = 28'h1234567;
        #1 check("axi_ready", {31'd0, axi_ready}, 1);
        @(negedge clk);
        axi_valid = 1'b0;
        check("axi_wr_en", {31'd0, wr_en}, 1);
        check("axi_addr", {22'd0, w_addr}, 5);
        check("axi_strb", {28'd0, w_strb}, 4'b0101);
        check("axi_din", {4'd0, din}, 28'h1234567);
        @(negedge clk);
        check("axi_idle_wr_en", {31'd0, wr_en}, 0);
        check("axi_idle_hold", {22'd0, w_addr}, 5);

        // Out-of-range AXI write
        axi_valid = 1'b1; axi_addr = 10'd600; axi_strb = 4'hF; axi_din = 28'hABCDEF0;
        #1 check("oor_ready", {31'd0, axi_ready}, 1);
        @(negedge clk);
        axi_valid = 1'b0;
        check("oor_wr_en", {31'd0, wr_en}, 0);
        check("oor_addr_hold", {22'd0, w_addr}, 5);
        check("oor_din_hold", {4'd0, din}, 28'h1234567);

        // Fill alone with char 0x20
        @(negedge clk);
        fill_start = 1'b1; fill_char = 7'h20;
        @(negedge clk);
        fill_start = 1'b0;
        check("fill_busy_on", {31'd0, fill_busy}, 1);
        check("fill_first_idle", {31'd0, wr_en}, 0);
        busy_cnt = int'(fill_busy);
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (wr_en !== 1'b1 || w_addr !== i[9:0] || din !== 28'h4081020 || w_strb !== 4'hF
                || fill_done !== (i == 599))
                bad++;
            busy_cnt += int'(fill_busy);
        end
        check("fill_seq", bad, 0);
        check("fill_busy_cycles", busy_cnt, 600);
        check("fill_done_pulse", {31'd0, fill_done}, 1);
        @(negedge clk);
        check("fill_end_done", {30'd0, fill_done, wr_en}, 0);

        // Fill under continuous AXI contention: AXI first, then strict alternation
        fill_start = 1'b1; fill_char = 7'h41;
        exp_fill = {4{7'h41}};
        @(negedge clk);
        fill_start = 1'b0;
        bad = 0; fidx = 0; prev_axi = 1'b0;
        for (int k = 1; k <= 1200; k++) begin
            if (k > 1) begin
                @(negedge clk);
                verify_prev(prev_axi);
            end
            axi_valid = 1'b1; axi_addr = 10'd10; axi_strb = 4'hF; axi_din = 28'h0AAAAAA;
            #1;
            exp_rdy = (k % 2 == 1);
            if (axi_ready !== exp_rdy) bad++;
            prev_axi = exp_rdy;
        end
        @(negedge clk);
        verify_prev(prev_axi);
        check("cont_done", {31'd0, fill_done}, 1);
        axi_valid = 1'b0;
        check("cont_seq", bad, 0);
        check("cont_fill_words", fidx, 600);

        // Abort at counter 300; start during DONE is ignored
        @(negedge clk);
        fill_start = 1'b1; fill_char = 7'h33;
        @(negedge clk);
        fill_start = 1'b0;
        bad = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (wr_en !== 1'b1 || w_addr !== 10'(k - 1)) bad++;
        end
        check("abort_pre_seq", bad, 0);
        fill_abort = 1'b1;
        @(negedge clk);
        fill_abort = 1'b0;
        check("abort_no_write", {31'd0, wr_en}, 0);
        check("abort_last_addr", {22'd0, w_addr}, 299);
        check("abort_done", {30'd0, fill_done, fill_busy}, 2'b10);
        fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        check("start_in_done_ignored", {30'd0, fill_busy, fill_done}, 0);
        @(negedge clk);
        check("start_in_done_no_wr", {31'd0, wr_en}, 0);

        // Asynchronous reset mid-fill
        fill_start = 1'b1; fill_char = 7'h55;
        @(negedge clk);
        fill_start = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_fill_wr", {31'd0, wr_en}, 1);
        #5 rstn = 1'b0;
        #1;
        check("arst_outputs", {28'd0, wr_en, fill_busy, fill_done, axi_ready}, 0);
        check("arst_addr", {22'd0, w_addr}, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("arst_no_done", {30'd0, fill_done, fill_busy}, 0);
        fill_start = 1'b1; fill_char = 7'h11;
        @(negedge clk);
        fill_start = 1'b0;
        @(negedge clk);
        check("restart_addr0", {21'd0, wr_en, w_addr}, {21'd0, 1'b1, 10'd0});
        check("restart_din", {4'd0, din}, {4'd0, {4{7'h11}}});
        fill_abort = 1'b1;
        @(negedge clk);
        fill_abort = 1'b0;
        @(negedge clk);

        // Fill gated by vblank on the FILL_IN_VBLANK instance
        vblank = 1'b0;
        fill_start = 1'b1; fill_char = 7'h7F;
        @(negedge clk);
        fill_start = 1'b0;
        check("vb_busy", {31'd0, vb_busy}, 1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (vb_wr_en !== 1'b0) bad++;
        end
        check("vb_hold_low", bad, 0);
        vblank = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (vb_wr_en !== 1'b1 || vb_addr !== i[9:0] || vb_din !== 28'hFFFFFFF) bad++;
        end
        check("vb_burst", bad, 0);
        vblank = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (vb_wr_en !== 1'b0) bad++;
        end
        check("vb_pause", bad, 0);
        vblank = 1'b1;
        @(negedge clk);
        check("vb_resume", {21'd0, vb_wr_en, vb_addr}, {21'd0, 1'b1, 10'd5});
        fill_abort = 1'b1;
        @(negedge clk);
        fill_abort = 1'b0;
        check("vb_abort_done", {31'd0, vb_done}, 1);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
